// File: rtl/ser_sched39x13_pkg.sv
// ser_pkg: shared widths, FSM states and slice selection for ser_sched39x13
package ser_pkg;
  localparam int W_OUT = 13;
  localparam int RATIO = 3;
  localparam int W_IN = W_OUT * RATIO;
  typedef enum logic {IDLE, SEND} state_t;
  function automatic logic [W_OUT-1:0] slice_sel(input logic [W_IN-1:0] w, input logic [1:0] idx);
    return idx == 2'd0 ? w[W_IN-1 -: W_OUT] : idx == 2'd1 ? w[W_IN-W_OUT-1 -: W_OUT] : w[W_OUT-1:0];
  endfunction
endpackage

// File: rtl/ser_sched39x13_if.sv
// ser_sched39x13_if: requester bus plus 13-bit output stream of the scheduler
interface ser_sched39x13_if import ser_pkg::*; #(parameter int N_REQ = 4);
  localparam int IW = $clog2(N_REQ);
  logic [N_REQ-1:0] reqValid;
  logic [N_REQ-1:0] reqReady;
  logic [N_REQ*W_IN-1:0] reqData;
  logic [W_OUT-1:0] dataOut;
  logic validOut;
  logic readyIn;
  logic firstOut;
  logic lastOut;
  logic [IW-1:0] grantId;
  logic busy;
  modport slave (
    input reqValid, reqData, readyIn,
    output reqReady, dataOut, validOut, firstOut, lastOut, grantId, busy
  );
  modport master (
    output reqValid, reqData, readyIn,
    input reqReady, dataOut, validOut, firstOut, lastOut, grantId, busy
  );
endinterface

// File: rtl/ser_sched39x13_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting one past the last winner
module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    gntIdx
);
  // Scan from lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    gnt = '0;
    gntIdx = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (en && req[(int'(last) + k) % N_REQ]) begin
        gnt = N_REQ'(1) << ((int'(last) + k) % N_REQ);
        gntIdx = IW'((int'(last) + k) % N_REQ);
      end
    end
  end
endmodule

// File: rtl/ser_sched39x13.sv
// ser_sched39x13: round-robin scheduler feeding one 39-to-13 serializer, MSB slice first
module ser_sched39x13 import ser_pkg::*; #(
  parameter int N_REQ = 4
) (
  input logic clkIn,
  input logic rstIn,
  ser_sched39x13_if.slave bus
);
  localparam int IW = $clog2(N_REQ);
  state_t state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [W_IN-1:0] word_q, word_d;
  logic [IW-1:0] last_q, last_d, gid_q, gid_d, win;
  logic [N_REQ-1:0] gnt;
  logic send, fire, load;
  assign send = state_q == SEND;
  assign fire = send & bus.readyIn;
  // The grant window reopens on the final-slice accept so words run back to back.
  assign load = !send | (fire & idx_q == 2'd2);
  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req(bus.reqValid),
    .last(last_q),
    .en(load),
    .gnt(gnt),
    .gntIdx(win)
  );
  always_comb begin
    state_d = fire && idx_q == 2'd2 ? IDLE : state_q;
    idx_d = fire ? (idx_q == 2'd2 ? 2'd0 : idx_q + 2'd1) : idx_q;
    word_d = word_q;
    last_d = last_q;
    gid_d = gid_q;
    if (|gnt) begin
      state_d = SEND;
      idx_d = 2'd0;
      word_d = bus.reqData[int'(win)*W_IN +: W_IN];
      last_d = win;
      gid_d = win;
    end
  end
  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      state_q <= IDLE;
      idx_q <= 2'd0;
      word_q <= '0;
      last_q <= IW'(N_REQ - 1);
      gid_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      word_q <= word_d;
      last_q <= last_d;
      gid_q <= gid_d;
    end
  end
  assign bus.reqReady = gnt;
  assign bus.dataOut = send ? slice_sel(word_q, idx_q) : '0;
  assign bus.validOut = send;
  assign bus.firstOut = send & idx_q == 2'd0;
  assign bus.lastOut = send & idx_q == 2'd2;
  assign bus.grantId = gid_q;
  assign bus.busy = send;
endmodule

// File: tb/tb_ser_sched39x13.sv
// tb_ser_sched39x13: table vectors, corner sequences and an every-cycle scoreboard
module tb_ser_sched39x13;
  import ser_pkg::*;
  localparam int N = 4;
  typedef struct {
    logic [W_OUT-1:0] d;
    logic f;
    logic l;
    logic [1:0] g;
  } slc_t;
  typedef struct {
    logic [N-1:0] rv;
    logic rdy;
    logic [N-1:0] rr;
    logic v;
    logic [W_OUT-1:0] d;
    logic f;
    logic l;
    logic [1:0] g;
  } vec_t;
  logic clkIn = 1'b0;
  logic rstIn;
  ser_sched39x13_if #(.N_REQ(N)) bus();
  ser_sched39x13 #(.N_REQ(N)) dut (.clkIn(clkIn), .rstIn(rstIn), .bus(bus.slave));
  int checks = 0;
  int errors = 0;
  slc_t q[$];
  int m_last = N - 1;
  bit mon_en = 1'b0;
  logic [W_IN-1:0] words [N];
  vec_t tbl [7];
  always #5 clkIn = ~clkIn;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic drive(input logic [N-1:0] rv, input logic rdy, input logic rst);
    @(posedge clkIn);
    #1;
    bus.reqValid = rv;
    bus.readyIn = rdy;
    rstIn = rst;
  endtask
  // Reference model: expected grant from own RR pointer, expected slices queued per grant.
  always @(negedge clkIn) begin
    if (mon_en) begin
      logic [N-1:0] er;
      int w;
      logic ld;
      er = '0;
      w = -1;
      ld = q.size() == 0 || (bus.readyIn && q[0].l);
      if (ld) begin
        for (int k = 1; k <= N; k++) begin
          int j;
          j = (m_last + k) % N;
          if (w < 0 && bus.reqValid[j]) w = j;
        end
      end
      if (w >= 0) er[w] = 1'b1;
      chk("reqReady", 64'(bus.reqReady), 64'(er));
      chk("busy", 64'(bus.busy), 64'(q.size() > 0));
      if (q.size() > 0) begin
        chk("validOut", 64'(bus.validOut), 64'd1);
        chk("dataOut", 64'(bus.dataOut), 64'(q[0].d));
        chk("firstOut", 64'(bus.firstOut), 64'(q[0].f));
        chk("lastOut", 64'(bus.lastOut), 64'(q[0].l));
        chk("grantId", 64'(bus.grantId), 64'(q[0].g));
      end else begin
        chk("idle_valid", 64'(bus.validOut), 64'd0);
        chk("idle_data", 64'(bus.dataOut), 64'd0);
        chk("idle_first", 64'(bus.firstOut), 64'd0);
        chk("idle_last", 64'(bus.lastOut), 64'd0);
      end
      if (rstIn) begin
        q.delete();
        m_last = N - 1;
      end else begin
        if (q.size() > 0 && bus.readyIn) void'(q.pop_front());
        if (w >= 0) begin
          for (int s = 0; s < RATIO; s++)
            q.push_back('{words[w][W_IN-1-s*W_OUT -: W_OUT], s == 0, s == RATIO-1, 2'(w)});
          m_last = w;
        end
      end
    end
  end
  initial begin
    rstIn = 1'b1;
    bus.reqValid = '0;
    bus.readyIn = 1'b0;
    words[0] = {13'h1ABC, 13'h0DEF, 13'h1234};
    for (int i = 1; i < N; i++) words[i] = W_IN'({$urandom(), $urandom()});
    for (int i = 0; i < N; i++) bus.reqData[i*W_IN +: W_IN] = words[i];
    tbl[0] = '{4'b0001, 1'b1, 4'b0001, 1'b0, 13'h0000, 1'b0, 1'b0, 2'd0};
    tbl[1] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 13'h1ABC, 1'b1, 1'b0, 2'd0};
    tbl[2] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 13'h1ABC, 1'b1, 1'b0, 2'd0};
    tbl[3] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 13'h0DEF, 1'b0, 1'b0, 2'd0};
    tbl[4] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 13'h0DEF, 1'b0, 1'b0, 2'd0};
    tbl[5] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 13'h1234, 1'b0, 1'b1, 2'd0};
    tbl[6] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 13'h0000, 1'b0, 1'b0, 2'd0};
    repeat (2) @(posedge clkIn);
    #1;
    rstIn = 1'b0;
    mon_en = 1'b1;
    @(negedge clkIn);
    chk("rst_valid", 64'(bus.validOut), 64'd0);
    chk("rst_gid", 64'(bus.grantId), 64'd0);
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].rv, tbl[i].rdy, 1'b0);
      @(negedge clkIn);
      chk("tbl_rr", 64'(bus.reqReady), 64'(tbl[i].rr));
      chk("tbl_v", 64'(bus.validOut), 64'(tbl[i].v));
      chk("tbl_d", 64'(bus.dataOut), 64'(tbl[i].d));
      chk("tbl_f", 64'(bus.firstOut), 64'(tbl[i].f));
      chk("tbl_l", 64'(bus.lastOut), 64'(tbl[i].l));
      chk("tbl_g", 64'(bus.grantId), 64'(tbl[i].g));
    end
    repeat (13) drive(4'b1111, 1'b1, 1'b0);
    repeat (4) drive(4'b0000, 1'b1, 1'b0);
    drive(4'b0100, 1'b1, 1'b0);
    drive(4'b0000, 1'b1, 1'b0);
    repeat (5) drive(4'b0000, 1'b0, 1'b0);
    repeat (3) drive(4'b0000, 1'b1, 1'b0);
    drive(4'b0100, 1'b1, 1'b0);
    repeat (2) drive(4'b0000, 1'b1, 1'b0);
    drive(4'b0001, 1'b1, 1'b0);
    @(negedge clkIn);
    chk("b2b_grant", 64'(bus.reqReady), 64'b0001);
    drive(4'b0000, 1'b1, 1'b0);
    @(negedge clkIn);
    chk("b2b_first", 64'(bus.firstOut), 64'd1);
    chk("b2b_gid", 64'(bus.grantId), 64'd0);
    repeat (3) drive(4'b0000, 1'b1, 1'b0);
    drive(4'b1000, 1'b1, 1'b0);
    drive(4'b0000, 1'b1, 1'b0);
    drive(4'b0000, 1'b1, 1'b1);
    drive(4'b0000, 1'b1, 1'b0);
    @(negedge clkIn);
    chk("postrst_busy", 64'(bus.busy), 64'd0);
    chk("postrst_data", 64'(bus.dataOut), 64'd0);
    chk("postrst_gid", 64'(bus.grantId), 64'd0);
    drive(4'b1111, 1'b1, 1'b0);
    @(negedge clkIn);
    chk("postrst_grant", 64'(bus.reqReady), 64'b0001);
    repeat (4) drive(4'b0000, 1'b1, 1'b0);
    drive(4'b0010, 1'b0, 1'b0);
    @(negedge clkIn);
    chk("idle_stall_grant", 64'(bus.reqReady), 64'b0010);
    drive(4'b0010, 1'b0, 1'b0);
    @(negedge clkIn);
    chk("stall_no_grant", 64'(bus.reqReady), 64'b0000);
    chk("stall_slice0", 64'(bus.dataOut), 64'(words[1][W_IN-1 -: W_OUT]));
    repeat (3) drive(4'b0010, 1'b0, 1'b0);
    repeat (4) drive(4'b0000, 1'b1, 1'b0);
    @(negedge clkIn);
    chk("sb_empty", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ser_sched39x13.md
# ser_sched39x13

Round-robin scheduler that shares one 39-to-13 word serializer among `N_REQ` requesters on a single clock. It accepts one 39-bit word per grant and emits it as three 13-bit slices, MSB slice first, under a valid/ready handshake. It sits between the parallel-word producers and the 13-bit output link, and replaces the free-running dual-clock serializer with a sequenced, back-pressurable one.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `W_IN`, 39: input word width. Fixed at 3 × `W_OUT`.
- `W_OUT`, 13: output slice width.

- `clkIn`  in  1  sole clock. All logic is on the rising edge.
- `rstIn`  in  1  reset, synchronous and active-high.
- `reqValid`  in  `N_REQ`  requester i holds a word.
- `reqData`  in  `N_REQ`×`W_IN`  requester i word at bits [i×39 +: 39].
- `reqReady`  out  `N_REQ`  one-hot grant; the word transfers on `reqValid[i] & reqReady[i]`.
- `dataOut`  out  `W_OUT`  current slice.
- `validOut`  out  1  `dataOut` is valid.
- `readyIn`  in  1  downstream accepts the slice.
- `firstOut`  out  1  current slice is slice 0 of its word.
- `lastOut`  out  1  current slice is slice 2 of its word.
- `grantId`  out  clog2(`N_REQ`)  source index of the word now being emitted.
- `busy`  out  1  a word is held.

## Operation
- States:
  - IDLE: no word held.
  - SEND: word held, slice counter `idx` runs 0..2.
- Reset values:
  - state IDLE, `idx` 0, word register 0.
  - RR pointer `last` = `N_REQ`-1, so requester 0 wins first.
  - All outputs 0.
- Grant window: `load = (state==IDLE) | (validOut & readyIn & idx==2)`.
- Arbitration:
  - When `load` is high and any `reqValid` is set, the winner is the first set bit searching cyclically from `last`+1.
  - `reqReady[winner]` = 1 in that cycle, combinationally. All other `reqReady` bits are 0. `reqReady` is never high outside the grant window.
- On a grant:
  - Word register ← `reqData[winner]`, `grantId` ← winner, `last` ← winner, `idx` ← 0, state SEND.
- SEND:
  - `validOut` = 1.
  - `dataOut` = word[38:26] when `idx`=0, word[25:13] when `idx`=1, word[12:0] when `idx`=2.
  - `firstOut` = (`idx`==0); `lastOut` = (`idx`==2).
  - `idx` advances only on `validOut & readyIn`.
- After the last slice is accepted:
  - With a new grant in the same cycle, stay in SEND with `idx`=0. There is no bubble.
  - Otherwise go to IDLE.
- In IDLE, `dataOut` is held at 0 and `validOut`, `firstOut`, `lastOut` are 0.
- Back-pressure: with `readyIn`=0, `dataOut`, `idx`, `firstOut` and `lastOut` stay stable. This is the standard valid/ready rule.
- A requester that drops `reqValid` without being granted loses nothing. It is not remembered.
- `rstIn` mid-word: the held word is discarded and every register returns to its reset value on that edge. No partial word resumes.

## Timing
- Latency: grant in cycle t puts slice 0 on `dataOut` in cycle t+1. With `readyIn` held at 1, slices occupy cycles t+1, t+2, t+3.
- Throughput with `readyIn`=1 and requests pending: one word every 3 cycles, one slice every cycle.
- `reqReady` depends combinationally on `reqValid`, state, `idx` and `readyIn`. No path runs from `reqData` to any output.
- `busy` = (state==SEND).

## Structure
- Package `ser_pkg` holds:
  - `W_IN`, `W_OUT`, `RATIO`=3.
  - State enum {IDLE, SEND}.
  - Slice-select function returning the `W_OUT`-bit slice for a given `idx`.
- Sub-module `rr_arbiter`, parameterised by `N_REQ`:
  - Inputs: `req`, `last`, `en`.
  - Outputs: one-hot `gnt`, binary `gntIdx`.
  - Purely combinational.
- Top level: FSM, `idx` counter, word register, `last` register.

## Test plan
- Single word, requester 0 sends {13'h1ABC, 13'h0DEF, 13'h1234}, `readyIn`=1 → `dataOut` reads 1ABC, 0DEF, 1234 on cycles t+1..t+3. `firstOut` is high only on 1ABC, `lastOut` only on 1234, `grantId`=0, then IDLE.
- All four requesters valid continuously → grants go 0,1,2,3,0. Exactly one `reqReady` bit is high, every 3rd cycle. 12 slices arrive with no gaps.
- `readyIn` low for 5 cycles during slice 1 → `dataOut` holds 0DEF and `idx` holds 1. Slice 2 follows one cycle after `readyIn` rises.
- Requester 2 alone valid, then requester 0 raises valid during the last slice → the back-to-back grant goes to 0 on the last-slice accept cycle. Its slice 0 appears on the next cycle with no bubble.
- `rstIn` pulsed during slice 1 → next cycle all outputs are 0 and state is IDLE. The next grant goes to requester 0.
- `readyIn`=0 in IDLE with requests pending → grant still occurs and slice 0 is presented. `reqReady` stays 0 until the last slice is accepted.
